// File: rtl/lsu_axi_resp_bridge.sv
// rtl/lsu_axi_resp_bridge.sv - single-beat AXI4 master servicing one LSU load/store at a time
module lsu_axi_resp_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic                we,
  input  logic                core_ready,
  input  logic [ADDR_W-1:0]   data_pc,
  input  logic [DATA_W-1:0]   data_o,
  input  logic [7:0]          wlen,
  input  logic [2:0]          data_size,
  output logic [DATA_W-1:0]   data_temp,
  output logic                data_valid,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic                axi_arvalid,
  output logic [2:0]          axi_arsize,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic                axi_awvalid,
  output logic [2:0]          axi_awsize,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [2:0]        size_q;
  logic              aw_done, w_done;
  logic              accept, r_hs, aw_hs, w_hs, b_hs;

  assign accept = (state == IDLE) && (re || we) && core_ready;
  assign r_hs   = axi_rvalid && axi_rready;
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign b_hs   = axi_bvalid && axi_bready;

  // Every bus-facing field comes from the request latch, never from the live LSU inputs.
  assign axi_araddr = addr_q;
  assign axi_awaddr = addr_q;
  assign axi_arsize = size_q;
  assign axi_awsize = size_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = strb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      size_q    <= 3'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      data_temp <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= data_pc;
        wdata_q <= data_o;
        strb_q  <= STRB_W'(wlen);
        size_q  <= (data_size == 3'd0) ? 3'd3 : data_size - 3'd3;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_hs) begin
        data_temp <= axi_rdata;
        if (axi_rresp != 2'b00) bus_err <= 1'b1;
      end
      if (b_hs && (axi_bresp != 2'b00)) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    data_valid  = 1'b1;
    case (state)
      IDLE:  if (accept) state_nxt = re ? RADDR : WREQ;  // a read wins over a simultaneous store
      RADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_nxt = RDATA;
      end
      RDATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_nxt = DONE;
      end
      WREQ: begin
        // AW and W retire independently; either may complete first or both together.
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
      end
      WRESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_nxt = DONE;
      end
      DONE: begin
        data_valid = 1'b0;
        state_nxt  = HOLD;
      end
      HOLD:    if (core_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_axi_resp_bridge.sv
// tb/tb_lsu_axi_resp_bridge.sv - randomized self-checking bench for lsu_axi_resp_bridge
module tb_lsu_axi_resp_bridge;
  logic        clk = 1'b0;
  logic        rst, re, we, core_ready;
  logic [63:0] data_pc, data_o, data_temp;
  logic [7:0]  wlen;
  logic [2:0]  data_size;
  logic        data_valid, bus_err;
  logic [63:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [7:0]  axi_wstrb;

  int          n_cmp = 0, n_fail = 0;
  logic [63:0] exp_temp = '0;
  logic        exp_err  = 1'b0;
  logic [2:0]  sz_tab [5] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6};

  int          o_lat, o_dv, o_ar, o_r, o_aw, o_w, o_b, o_arhi, o_awhi, o_whi, o_rw, o_bw;
  logic [63:0] o_araddr, o_awaddr, o_wdata;
  logic [7:0]  o_wstrb;
  logic [2:0]  o_arsize, o_awsize;
  bit          o_stable, o_timeout;

  always #5 clk = ~clk;

  lsu_axi_resp_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .core_ready(core_ready),
    .data_pc(data_pc), .data_o(data_o), .wlen(wlen), .data_size(data_size),
    .data_temp(data_temp), .data_valid(data_valid), .bus_err(bus_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arsize(axi_arsize), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awsize(axi_awsize), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic slave_idle();
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
  endtask

  // Issues one request at a negedge in IDLE, plays a delayed AXI slave, and records what it saw.
  // Returns at the negedge two cycles after the completion pulse (DUT back in IDLE).
  task automatic run_txn(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] strb, input logic [2:0] sz, input int ar_d, input int r_d,
                         input int aw_d, input int w_d, input int b_d, input logic [63:0] rdat,
                         input logic [1:0] resp);
    int c, post;
    bit seen_ar, seen_aw, seen_w;
    o_lat = -1; o_dv = 0; o_ar = 0; o_r = 0; o_aw = 0; o_w = 0; o_b = 0;
    o_arhi = 0; o_awhi = 0; o_whi = 0; o_rw = 0; o_bw = 0;
    o_araddr = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0; o_arsize = '0; o_awsize = '0;
    o_stable = 1'b1; seen_ar = 0; seen_aw = 0; seen_w = 0;
    slave_idle();
    re = rd; we = wr; data_pc = addr; data_o = wd; wlen = strb; data_size = sz; core_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    data_pc = {$urandom(), $urandom()}; data_o = {$urandom(), $urandom()};
    wlen = 8'($urandom()); data_size = 3'($urandom());
    c = 1; post = -1;
    while (post < 2 && c < 200) begin
      if (axi_arvalid === 1'b1) begin
        if (!seen_ar) begin o_araddr = axi_araddr; o_arsize = axi_arsize; seen_ar = 1; end
        else if (axi_araddr !== o_araddr || axi_arsize !== o_arsize) o_stable = 0;
        axi_arready = (o_arhi >= ar_d); o_arhi++;
        if (axi_arready) o_ar++;
      end else axi_arready = 1'b0;
      if (axi_rready === 1'b1) begin
        axi_rvalid = (o_rw >= r_d); o_rw++;
        axi_rdata = axi_rvalid ? rdat : {$urandom(), $urandom()}; axi_rresp = resp;
        if (axi_rvalid) o_r++;
      end else axi_rvalid = 1'b0;
      if (axi_awvalid === 1'b1) begin
        if (!seen_aw) begin o_awaddr = axi_awaddr; o_awsize = axi_awsize; seen_aw = 1; end
        else if (axi_awaddr !== o_awaddr || axi_awsize !== o_awsize) o_stable = 0;
        axi_awready = (o_awhi >= aw_d); o_awhi++;
        if (axi_awready) o_aw++;
      end else axi_awready = 1'b0;
      if (axi_wvalid === 1'b1) begin
        if (!seen_w) begin o_wdata = axi_wdata; o_wstrb = axi_wstrb; seen_w = 1; end
        else if (axi_wdata !== o_wdata || axi_wstrb !== o_wstrb) o_stable = 0;
        axi_wready = (o_whi >= w_d); o_whi++;
        if (axi_wready) o_w++;
      end else axi_wready = 1'b0;
      if (axi_bready === 1'b1) begin
        axi_bvalid = (o_bw >= b_d); o_bw++; axi_bresp = resp;
        if (axi_bvalid) o_b++;
      end else axi_bvalid = 1'b0;
      if (data_valid === 1'b0) o_dv++;
      if (data_valid === 1'b0 && post < 0) begin o_lat = c; post = 0; end
      else if (post >= 0) post++;
      @(negedge clk); c++;
    end
    o_timeout = (post < 2);
    slave_idle();
  endtask

  task automatic test_reset();
    n_cmp++; if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b expected 00000", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}); end
    n_cmp++; if ({data_valid, bus_err} !== 2'b10) begin
      n_fail++; $display("FAIL reset_status: got dv/err=%b expected 10", {data_valid, bus_err}); end
    n_cmp++; if (data_temp !== 64'h0) begin
      n_fail++; $display("FAIL reset_data_temp: got %h expected 0", data_temp); end
  endtask

  task automatic test_load();
    run_txn(1, 0, 64'h8000_0008, 64'h0, 8'h00, 3'b110, 0, 0, 0, 0, 0, 64'h1122334455667788, 2'b00);
    exp_temp = 64'h1122334455667788;
    n_cmp++; if ({o_araddr, o_arsize} !== {64'h8000_0008, 3'd3}) begin
      n_fail++; $display("FAIL load_ar: got %h/%0d expected 80000008/3", o_araddr, o_arsize); end
    n_cmp++; if (o_lat !== 3) begin
      n_fail++; $display("FAIL load_latency: got %0d expected 3", o_lat); end
    n_cmp++; if (data_temp !== exp_temp) begin
      n_fail++; $display("FAIL load_data: got %h expected %h", data_temp, exp_temp); end
    n_cmp++; if (o_dv !== 1 || o_timeout) begin
      n_fail++; $display("FAIL load_pulse: got %0d pulses timeout=%0b expected 1/0", o_dv, o_timeout); end
  endtask

  task automatic test_store();
    run_txn(0, 1, 64'h8000_0003, 64'h00000000AB000000, 8'h08, 3'b011, 0, 0, 2, 0, 0, 64'h0, 2'b00);
    n_cmp++; if ({o_awhi, o_whi} !== {32'd3, 32'd1}) begin
      n_fail++; $display("FAIL store_valid_len: got aw=%0d w=%0d expected aw=3 w=1", o_awhi, o_whi); end
    n_cmp++; if ({o_awaddr, o_awsize, o_wdata, o_wstrb} !== {64'h8000_0003, 3'd0, 64'h00000000AB000000, 8'h08}) begin
      n_fail++; $display("FAIL store_fields: got %h/%0d/%h/%h expected 80000003/0/ab000000/08", o_awaddr, o_awsize, o_wdata, o_wstrb); end
    n_cmp++; if (o_b !== 1 || o_dv !== 1 || o_ar !== 0) begin
      n_fail++; $display("FAIL store_handshakes: got b=%0d dv=%0d ar=%0d expected 1/1/0", o_b, o_dv, o_ar); end
    n_cmp++; if (o_lat !== 5) begin
      n_fail++; $display("FAIL store_latency: got %0d expected 5", o_lat); end
    n_cmp++; if (data_temp !== exp_temp) begin
      n_fail++; $display("FAIL store_keeps_data: got %h expected %h", data_temp, exp_temp); end
  endtask

  task automatic test_rw_both();
    run_txn(1, 1, 64'h100, 64'hDEAD, 8'hFF, 3'b110, 0, 0, 0, 0, 0, 64'h0BAD_F00D_0000_0001, 2'b00);
    exp_temp = 64'h0BAD_F00D_0000_0001;
    n_cmp++; if (o_awhi !== 0 || o_whi !== 0 || o_ar !== 1) begin
      n_fail++; $display("FAIL rw_both_channels: got awhi=%0d whi=%0d ar=%0d expected 0/0/1", o_awhi, o_whi, o_ar); end
    n_cmp++; if (o_araddr !== 64'h100 || data_temp !== exp_temp) begin
      n_fail++; $display("FAIL rw_both_read: got %h/%h expected 100/%h", o_araddr, data_temp, exp_temp); end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 64'hCAFE_0000_BEEF_0001; axi_rresp = 2'b00;
    re = 1'b1; we = 1'b0; data_pc = 64'h2000; data_size = 3'b110; core_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_done_pulse: got %b expected 0", data_valid); end
    core_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (axi_arvalid !== 1'b0 || data_valid !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin
      n_fail++; $display("FAIL hold_stall: got %0d bad cycles expected 0", bad); end
    core_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (axi_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle_cycle: got arvalid %b expected 0", axi_arvalid); end
    @(negedge clk);
    re = 1'b0;
    n_cmp++; if (axi_arvalid !== 1'b1 || axi_araddr !== 64'h2000) begin
      n_fail++; $display("FAIL hold_reissue: got %b/%h expected 1/2000", axi_arvalid, axi_araddr); end
    repeat (5) @(negedge clk);
    exp_temp = 64'hCAFE_0000_BEEF_0001;
    n_cmp++; if (data_temp !== exp_temp) begin
      n_fail++; $display("FAIL hold_data: got %h expected %h", data_temp, exp_temp); end
    slave_idle();
  endtask

  task automatic test_error();
    run_txn(1, 0, 64'h40, 64'h0, 8'h0, 3'b110, 1, 1, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 2'b10);
    exp_temp = 64'h5555_AAAA_5555_AAAA; exp_err = 1'b1;
    n_cmp++; if (bus_err !== 1'b1 || o_dv !== 1) begin
      n_fail++; $display("FAIL error_set: got err=%b dv=%0d expected 1/1", bus_err, o_dv); end
    n_cmp++; if (data_temp !== exp_temp) begin
      n_fail++; $display("FAIL error_data: got %h expected %h", data_temp, exp_temp); end
    run_txn(1, 0, 64'h48, 64'h0, 8'h0, 3'b110, 0, 0, 0, 0, 0, 64'h1, 2'b00);
    run_txn(0, 1, 64'h50, 64'h7, 8'h01, 3'b011, 0, 0, 0, 0, 0, 64'h0, 2'b00);
    exp_temp = 64'h1;
    n_cmp++; if (bus_err !== 1'b1) begin
      n_fail++; $display("FAIL error_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_reset_mid();
    slave_idle();
    re = 1'b1; we = 1'b0; data_pc = 64'h3000; data_size = 3'b110; core_ready = 1'b1;
    @(negedge clk);
    re = 1'b0;
    n_cmp++; if (axi_arvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got arvalid %b expected 1", axi_arvalid); end
    #2 rst = 1'b0;
    #1;
    exp_err = 1'b0; exp_temp = '0;
    n_cmp++; if ({axi_arvalid, data_valid, bus_err} !== 3'b010 || data_temp !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_async: got arv/dv/err=%b temp=%h expected 010/0", {axi_arvalid, data_valid, bus_err}, data_temp); end
    @(negedge clk);
    rst = 1'b1;
    run_txn(1, 0, 64'h3008, 64'h0, 8'h0, 3'b110, 0, 0, 0, 0, 0, 64'h7777_8888_9999_0000, 2'b00);
    exp_temp = 64'h7777_8888_9999_0000;
    n_cmp++; if (o_lat !== 3 || o_araddr !== 64'h3008 || data_temp !== exp_temp || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got lat=%0d addr=%h temp=%h err=%b expected 3/3008/%h/0", o_lat, o_araddr, data_temp, bus_err, exp_temp); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      bit rd, wr, is_rd;
      logic [63:0] addr, wd, rdat;
      logic [7:0] strb;
      logic [2:0] sz, exp_sz;
      logic [1:0] resp;
      int ar_d, r_d, aw_d, w_d, b_d, exp_lat;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      is_rd = rd;
      sz = sz_tab[$urandom_range(0, 4)];
      exp_sz = (sz == 3'd0) ? 3'd3 : sz - 3'd3;
      addr = {$urandom(), $urandom()};
      if (is_rd) addr[2:0] = 3'b000;
      wd = {$urandom(), $urandom()}; rdat = {$urandom(), $urandom()}; strb = 8'($urandom());
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      run_txn(rd, wr, addr, wd, strb, sz, ar_d, r_d, aw_d, w_d, b_d, rdat, resp);
      if (resp != 2'b00) exp_err = 1'b1;
      if (is_rd) begin
        exp_temp = rdat;
        exp_lat = 3 + ar_d + r_d;
      end else exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      n_cmp++; if (o_timeout || o_lat !== exp_lat || o_dv !== 1) begin
        n_fail++; $display("FAIL rand[%0d] timing: got lat=%0d pulses=%0d timeout=%0b expected %0d/1/0", i, o_lat, o_dv, o_timeout, exp_lat); end
      n_cmp++; if (data_temp !== exp_temp || bus_err !== exp_err) begin
        n_fail++; $display("FAIL rand[%0d] result: got %h/%b expected %h/%b", i, data_temp, bus_err, exp_temp, exp_err); end
      n_cmp++; if (o_stable !== 1'b1) begin
        n_fail++; $display("FAIL rand[%0d] stability: got 0 expected 1", i); end
      if (is_rd) begin
        n_cmp++; if (o_ar !== 1 || o_r !== 1 || (o_aw + o_w + o_b + o_awhi + o_whi) !== 0) begin
          n_fail++; $display("FAIL rand[%0d] rd_channels: got ar=%0d r=%0d aw=%0d w=%0d expected 1/1/0/0", i, o_ar, o_r, o_awhi, o_whi); end
        n_cmp++; if ({o_araddr, o_arsize} !== {addr, exp_sz} || o_arhi !== ar_d + 1) begin
          n_fail++; $display("FAIL rand[%0d] ar: got %h/%0d/%0d expected %h/%0d/%0d", i, o_araddr, o_arsize, o_arhi, addr, exp_sz, ar_d + 1); end
      end else begin
        n_cmp++; if (o_aw !== 1 || o_w !== 1 || o_b !== 1 || (o_ar + o_r + o_arhi) !== 0) begin
          n_fail++; $display("FAIL rand[%0d] wr_channels: got aw=%0d w=%0d b=%0d ar=%0d expected 1/1/1/0", i, o_aw, o_w, o_b, o_arhi); end
        n_cmp++; if ({o_awaddr, o_awsize, o_wdata, o_wstrb} !== {addr, exp_sz, wd, strb}) begin
          n_fail++; $display("FAIL rand[%0d] wfields: got %h/%0d/%h/%h expected %h/%0d/%h/%h", i, o_awaddr, o_awsize, o_wdata, o_wstrb, addr, exp_sz, wd, strb); end
        n_cmp++; if (o_awhi !== aw_d + 1 || o_whi !== w_d + 1) begin
          n_fail++; $display("FAIL rand[%0d] wvalid_len: got %0d/%0d expected %0d/%0d", i, o_awhi, o_whi, aw_d + 1, w_d + 1); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; re = 1'b0; we = 1'b0; core_ready = 1'b0;
    data_pc = '0; data_o = '0; wlen = '0; data_size = '0;
    slave_idle();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_load();
    test_store();
    test_rw_both();
    test_hold();
    test_random(30);
    test_error();
    test_reset_mid();
    test_random(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
